// File: rtl/multdiv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : multdiv_pkg                                        |
// | Description : Shared types and constants for the iterative       |
// |               multiply/divide unit (FSM states, op select,       |
// |               default datapath width).                           |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
package multdiv_pkg;

  localparam int c_default_width = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef enum logic {
    OP_MULT = 1'b0,
    OP_DIV  = 1'b1
  } op_t;

endpackage
`default_nettype wire

// File: rtl/multdiv_step.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : multdiv_step                                       |
// | Description : One iteration of the magnitude datapath. Multiply: |
// |               conditional add of the multiplicand into the high  |
// |               half, then shift {hi,lo} right by one. Divide:     |
// |               shift {hi,lo} left by one, trial-subtract the      |
// |               divisor and keep the difference only if it fits.   |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module multdiv_step
  import multdiv_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  op_t              i_op,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  logic [WIDTH-1:0] w_addend;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_qbit;

  // Single-cycle shift-add or subtract/restore on the running {hi,lo} pair.
  // The partial remainder is always below the divisor, so after the left
  // shift it needs only one extra bit; a set top bit means the trial
  // subtraction must succeed and the W-bit wrapped difference is exact.
  always_comb begin
    w_addend = i_lo[0] ? i_b : '0;
    w_sum    = {1'b0, i_hi} + {1'b0, w_addend};
    w_shift  = {i_hi, i_lo[WIDTH-1]};
    w_qbit   = w_shift[WIDTH] | (w_shift[WIDTH-1:0] >= i_b);
    w_diff   = w_shift[WIDTH-1:0] - i_b;
    if (i_op == OP_MULT) begin
      o_hi = w_sum[WIDTH:1];
      o_lo = {w_sum[0], i_lo[WIDTH-1:1]};
    end else begin
      o_hi = w_qbit ? w_diff : w_shift[WIDTH-1:0];
      o_lo = {i_lo[WIDTH-2:0], w_qbit};
    end
  end

endmodule
`default_nettype wire

// File: rtl/multdiv_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : multdiv_iter                                       |
// | Description : Iterative signed/unsigned multiplier and restoring |
// |               divider, one bit per cycle, fixed WIDTH+1 cycle    |
// |               latency from start to the result-ready pulse.      |
// |               Define MULTDIV_REMAINDER_EN to add the remainder   |
// |               output port and its register.                      |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module multdiv_iter
  import multdiv_pkg::*;
#(
  parameter int WIDTH = c_default_width,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  input  logic             ctrl_SIGNED,
  output logic [WIDTH-1:0] data_result,
`ifdef MULTDIV_REMAINDER_EN
  output logic [WIDTH-1:0] data_remainder,
`endif
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_next;
  op_t              r_op;
  logic             r_signed;
  logic             r_neg_a;
  logic             r_neg_b;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_b;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_exception;
  logic             r_rdy;
`ifdef MULTDIV_REMAINDER_EN
  logic [WIDTH-1:0] r_remainder;
  logic [WIDTH-1:0] w_rem;
`endif

  logic             w_start;
  logic             w_last;
  logic             w_neg_a_in;
  logic             w_neg_b_in;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic [WIDTH-1:0] w_hi_next;
  logic [WIDTH-1:0] w_lo_next;
  logic             w_neg_res;
  logic [WIDTH-1:0] w_lo_signed;
  logic             w_div_zero;
  logic [WIDTH-1:0] w_res;
  logic             w_exc;

  // A start needs exactly one of the two pulses; both together are ignored.
  assign w_start    = ctrl_MULT ^ ctrl_DIV;
  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  assign w_neg_a_in = ctrl_SIGNED & data_operandA[WIDTH-1];
  assign w_neg_b_in = ctrl_SIGNED & data_operandB[WIDTH-1];
  assign w_mag_a    = w_neg_a_in ? (-data_operandA) : data_operandA;
  assign w_mag_b    = w_neg_b_in ? (-data_operandB) : data_operandB;

  multdiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_op (r_op),
    .i_hi (r_hi),
    .i_lo (r_lo),
    .i_b  (r_b),
    .o_hi (w_hi_next),
    .o_lo (w_lo_next)
  );

  // State register; reset wins over a coincident start.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: any valid start (re)launches, otherwise iterate WIDTH times.
  always_comb begin
    w_state_next = r_state;
    if (w_start) begin
      w_state_next = ctrl_MULT ? MULT : DIV;
    end else begin
      case (r_state)
        MULT, DIV: if (w_last) w_state_next = DONE;
        DONE:      w_state_next = IDLE;
        default:   w_state_next = r_state;
      endcase
    end
  end

  // Sign fix-up and exception detection applied to the magnitude result.
  // A signed product of magnitude exactly 2^(WIDTH-1) only fits when negative;
  // a positive signed quotient with the top bit set can only be MIN / -1.
  always_comb begin
    w_neg_res   = r_neg_a ^ r_neg_b;
    w_lo_signed = w_neg_res ? (-r_lo) : r_lo;
    w_div_zero  = (r_b == '0);
    if (r_op == OP_MULT) begin
      w_res = w_lo_signed;
      if (r_signed) begin
        w_exc = (|r_hi) | (r_lo[WIDTH-1] & ~(w_neg_res & ~(|r_lo[WIDTH-2:0])));
      end else begin
        w_exc = |r_hi;
      end
    end else begin
      w_res = w_div_zero ? '0 : w_lo_signed;
      w_exc = w_div_zero | (r_signed & ~w_neg_res & r_lo[WIDTH-1]);
    end
  end

`ifdef MULTDIV_REMAINDER_EN
  // Remainder carries the dividend's sign; divide-by-zero leaves it equal to the dividend.
  assign w_rem = r_neg_a ? (-r_hi) : r_hi;
`endif

  // Operand latch, iteration datapath, counter and registered results.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_op        <= OP_MULT;
      r_signed    <= 1'b0;
      r_neg_a     <= 1'b0;
      r_neg_b     <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_b         <= '0;
      r_cnt       <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
      r_remainder <= '0;
`endif
    end else begin
      r_rdy <= 1'b0;
      if (w_start) begin
        r_op     <= ctrl_MULT ? OP_MULT : OP_DIV;
        r_signed <= ctrl_SIGNED;
        r_neg_a  <= w_neg_a_in;
        r_neg_b  <= w_neg_b_in;
        r_hi     <= '0;
        r_lo     <= w_mag_a;
        r_b      <= w_mag_b;
        r_cnt    <= '0;
      end else if ((r_state == MULT) || (r_state == DIV)) begin
        r_hi  <= w_hi_next;
        r_lo  <= w_lo_next;
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (r_state == DONE) begin
        r_result    <= w_res;
        r_exception <= w_exc;
        r_rdy       <= 1'b1;
`ifdef MULTDIV_REMAINDER_EN
        if (r_op == OP_DIV) r_remainder <= w_rem;
`endif
      end
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exception;
  assign data_resultRDY = r_rdy;
  assign busy           = (r_state != IDLE) | r_rdy;
`ifdef MULTDIV_REMAINDER_EN
  assign data_remainder = r_remainder;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multdiv_iter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_multdiv_iter                                    |
// | Description : Self-checking bench for multdiv_iter (WIDTH=32),   |
// |               directed corner vectors plus randomized operations |
// |               against an arithmetic reference model.             |
// | Revision    : 1.0 - initial release                              |
// +------------------------------------------------------------------+
module tb_multdiv_iter;

  localparam int W     = 32;
  localparam int LIMIT = 100;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] data_operandA;
  logic [W-1:0] data_operandB;
  logic         ctrl_MULT;
  logic         ctrl_DIV;
  logic         ctrl_SIGNED;
  logic [W-1:0] data_result;
  logic [W-1:0] rem_w;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit         is_div;
    bit         sgn;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic [W-1:0] rem;
    bit         exc;
    bit         chk_rem;
  } vec_t;

  multdiv_iter #(
    .WIDTH (W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .ctrl_SIGNED    (ctrl_SIGNED),
    .data_result    (data_result),
`ifdef MULTDIV_REMAINDER_EN
    .data_remainder (rem_w),
`endif
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

`ifndef MULTDIV_REMAINDER_EN
  assign rem_w = '0;
`endif

  always #5 clock = ~clock;

  // Reference model: plain integer arithmetic on the mode's interpretation.
  task automatic model(input bit is_div, input bit sgn, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] res,
                       output logic [W-1:0] rem, output bit exc);
    longint          sp;
    longint unsigned up;
    int              sa, sb, t;
    rem = '0;
    sa  = $signed(a);
    sb  = $signed(b);
    if (!is_div) begin
      if (sgn) begin
        sp  = longint'(sa) * longint'(sb);
        res = sp[W-1:0];
        t   = int'(sp[W-1:0]);
        exc = (sp != longint'(t));
      end else begin
        up  = {32'b0, a} * {32'b0, b};
        res = up[W-1:0];
        exc = (up[63:32] != 0);
      end
    end else if (b == 0) begin
      res = '0; rem = a; exc = 1'b1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = a; rem = '0; exc = 1'b1;
    end else if (sgn) begin
      res = sa / sb; rem = sa % sb; exc = 1'b0;
    end else begin
      res = a / b; rem = a % b; exc = 1'b0;
    end
  endtask

  // Drive one start pulse so it is sampled on the next rising edge, then scramble operands.
  task automatic pulse(input bit m, input bit d, input bit sgn,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    ctrl_SIGNED   = sgn;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    ctrl_SIGNED   = 1'($urandom_range(0, 1));
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Wait for the ready pulse (bounded); k0 is the cycle count already elapsed since start.
  task automatic wait_done(input int k0, output int cycles, output bit busy_ok,
                           output bit after_rdy, output bit after_busy,
                           output logic [W-1:0] res_at, output logic [W-1:0] rem_at,
                           output bit exc_at);
    int k;
    k = k0; cycles = -1; busy_ok = 1'b1;
    after_rdy = 1'b0; after_busy = 1'b0; res_at = 'x; rem_at = 'x; exc_at = 1'b0;
    while (k <= LIMIT && cycles < 0) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (data_resultRDY === 1'b1) begin
        cycles = k;
        res_at = data_result;
        rem_at = rem_w;
        exc_at = data_exception;
      end else begin
        @(posedge clock);
        #1;
        k++;
      end
    end
    if (cycles >= 0) begin
      @(posedge clock);
      #1;
      after_rdy  = data_resultRDY;
      after_busy = busy;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ctrl_MULT = 1'b0; ctrl_DIV = 1'b0; ctrl_SIGNED = 1'b0;
    data_operandA = '0; data_operandB = '0;
    repeat (3) @(posedge clock);
    #1;
    total++; if (data_result !== '0) begin bad++; $display("FAIL reset_result: got %h want 0", data_result); end
    total++; if (data_exception !== 1'b0) begin bad++; $display("FAIL reset_exc: got %b want 0", data_exception); end
    total++; if (data_resultRDY !== 1'b0) begin bad++; $display("FAIL reset_rdy: got %b want 0", data_resultRDY); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
`ifdef MULTDIV_REMAINDER_EN
    total++; if (rem_w !== '0) begin bad++; $display("FAIL reset_rem: got %h want 0", rem_w); end
`endif
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_directed();
    vec_t v[$];
    int cyc; bit bok, ardy, abusy, e;
    logic [W-1:0] r, rm;
    v.push_back('{1'b0, 1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 32'd0,         1'b0, 1'b0});
    v.push_back('{1'b1, 1'b1, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0, 1'b1});
    v.push_back('{1'b1, 1'b0, 32'hFFFF_FFFF,  32'd2,         32'h7FFF_FFFF, 32'd1,         1'b0, 1'b1});
    v.push_back('{1'b1, 1'b0, 32'd5,          32'd0,         32'd0,         32'd5,         1'b1, 1'b1});
    v.push_back('{1'b1, 1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b1, 1'b1});
    v.push_back('{1'b0, 1'b1, 32'd65536,      32'd65536,     32'd0,         32'd0,         1'b1, 1'b0});
    v.push_back('{1'b0, 1'b0, 32'hFFFF,       32'hFFFF,      32'hFFFE_0001, 32'd0,         1'b0, 1'b0});
    v.push_back('{1'b1, 1'b1, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b1});
    v.push_back('{1'b1, 1'b1, 32'hFFFF_FFFB,  32'd0,         32'd0,         32'hFFFF_FFFB, 1'b1, 1'b1});
    v.push_back('{1'b0, 1'b1, 32'h8000,       32'hFFFF_0000, 32'h8000_0000, 32'd0,         1'b0, 1'b0});
    v.push_back('{1'b0, 1'b1, 32'h8000,       32'h0001_0000, 32'h8000_0000, 32'd0,         1'b1, 1'b0});
    v.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFE, 32'd0,         1'b1, 1'b0});
    v.push_back('{1'b1, 1'b0, 32'd7,          32'd9,         32'd0,         32'd7,         1'b0, 1'b1});
    v.push_back('{1'b1, 1'b1, 32'h8000_0000,  32'd1,         32'h8000_0000, 32'd0,         1'b0, 1'b1});
    for (int i = 0; i < v.size(); i++) begin
      pulse(!v[i].is_div, v[i].is_div, v[i].sgn, v[i].a, v[i].b);
      wait_done(0, cyc, bok, ardy, abusy, r, rm, e);
      total++; if (cyc != W + 1) begin bad++; $display("FAIL dir%0d_latency: got %0d want %0d", i, cyc, W + 1); end
      total++; if (!bok) begin bad++; $display("FAIL dir%0d_busy: busy dropped before ready, want 1", i); end
      total++; if (r !== v[i].res) begin bad++; $display("FAIL dir%0d_result: got %h want %h", i, r, v[i].res); end
      total++; if (e !== v[i].exc) begin bad++; $display("FAIL dir%0d_exc: got %b want %b", i, e, v[i].exc); end
`ifdef MULTDIV_REMAINDER_EN
      if (v[i].chk_rem) begin
        total++; if (rm !== v[i].rem) begin bad++; $display("FAIL dir%0d_rem: got %h want %h", i, rm, v[i].rem); end
      end
`endif
      total++; if (ardy !== 1'b0 || abusy !== 1'b0) begin bad++; $display("FAIL dir%0d_after: rdy=%b busy=%b want 0 0", i, ardy, abusy); end
      total++; if (data_result !== v[i].res) begin bad++; $display("FAIL dir%0d_hold: got %h want %h", i, data_result, v[i].res); end
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 255));
      6:       return 32'(0 - $urandom_range(1, 255));
      default: return $urandom;
    endcase
  endfunction

  task automatic test_random();
    int cyc; bit bok, ardy, abusy, e, ee, is_div, sgn;
    logic [W-1:0] r, rm, a, b, er, erm;
    for (int i = 0; i < 40; i++) begin
      is_div = 1'($urandom_range(0, 1));
      sgn    = 1'($urandom_range(0, 1));
      a      = pick();
      b      = pick();
      model(is_div, sgn, a, b, er, erm, ee);
      pulse(!is_div, is_div, sgn, a, b);
      wait_done(0, cyc, bok, ardy, abusy, r, rm, e);
      total++; if (cyc != W + 1) begin bad++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, cyc, W + 1); end
      total++; if (r !== er || e !== ee) begin
        bad++; $display("FAIL rnd%0d_result: div=%b sgn=%b a=%h b=%h got %h/%b want %h/%b", i, is_div, sgn, a, b, r, e, er, ee);
      end
`ifdef MULTDIV_REMAINDER_EN
      if (is_div) begin
        total++; if (rm !== erm) begin bad++; $display("FAIL rnd%0d_rem: a=%h b=%h got %h want %h", i, a, b, rm, erm); end
      end
`endif
      total++; if (!bok || ardy !== 1'b0) begin bad++; $display("FAIL rnd%0d_handshake: busy_ok=%b after_rdy=%b want 1 0", i, bok, ardy); end
    end
  endtask

  task automatic test_both_high();
    int cyc; bit bok, ardy, abusy, e;
    logic [W-1:0] r, rm;
    pulse(1'b1, 1'b0, 1'b0, 32'd6, 32'd7);
    repeat (3) @(posedge clock);
    pulse(1'b1, 1'b1, 1'b1, 32'hDEAD, 32'hBEEF);
    wait_done(4, cyc, bok, ardy, abusy, r, rm, e);
    total++; if (cyc != W + 1) begin bad++; $display("FAIL both_latency: got %0d want %0d", cyc, W + 1); end
    total++; if (r !== 32'd42 || e !== 1'b0) begin bad++; $display("FAIL both_result: got %h/%b want 0000002a/0", r, e); end
    pulse(1'b1, 1'b1, 1'b0, 32'd3, 32'd3);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL both_idle_busy: got %b want 0", busy); end
    total++; if (data_result !== 32'd42) begin bad++; $display("FAIL both_idle_hold: got %h want 0000002a", data_result); end
  endtask

  task automatic test_abort();
    int cyc, extra; bit bok, ardy, abusy, e;
    logic [W-1:0] r, rm;
    extra = 0;
    pulse(1'b0, 1'b1, 1'b0, 32'd9, 32'd3);
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1) extra++;
    end
    pulse(1'b1, 1'b0, 1'b0, 32'd3, 32'd4);
    wait_done(0, cyc, bok, ardy, abusy, r, rm, e);
    total++; if (extra != 0) begin bad++; $display("FAIL abort_early_rdy: got %0d pulses want 0", extra); end
    total++; if (cyc != W + 1) begin bad++; $display("FAIL abort_latency: got %0d want %0d", cyc, W + 1); end
    total++; if (r !== 32'd12) begin bad++; $display("FAIL abort_result: got %h want 0000000c", r); end
    total++; if (ardy !== 1'b0) begin bad++; $display("FAIL abort_second_rdy: got %b want 0", ardy); end
  endtask

  task automatic test_reset_mid();
    int cyc, seen; bit bok, ardy, abusy, e;
    logic [W-1:0] r, rm;
    seen = 0;
    pulse(1'b1, 1'b0, 1'b1, 32'd123, 32'd456);
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    total++; if (data_result !== '0 || data_exception !== 1'b0) begin
      bad++; $display("FAIL rstmid_outputs: got %h/%b want 0/0", data_result, data_exception);
    end
    total++; if (busy !== 1'b0 || data_resultRDY !== 1'b0) begin
      bad++; $display("FAIL rstmid_ctrl: busy=%b rdy=%b want 0 0", busy, data_resultRDY);
    end
    pulse(1'b1, 1'b0, 1'b0, 32'd5, 32'd5);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_start_ignored: busy=%b want 0", busy); end
    @(negedge clock);
    reset = 1'b0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY === 1'b1 || busy === 1'b1) seen++;
    end
    total++; if (seen != 0) begin bad++; $display("FAIL rstmid_no_rdy: got %0d active cycles want 0", seen); end
    pulse(1'b1, 1'b0, 1'b0, 32'd2, 32'd2);
    wait_done(0, cyc, bok, ardy, abusy, r, rm, e);
    total++; if (cyc != W + 1 || r !== 32'd4) begin
      bad++; $display("FAIL rstmid_next_op: latency=%0d result=%h want %0d 00000004", cyc, r, W + 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_both_high();
    test_abort();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
